stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Game-state stage directly upstream of the stack renderer. Owns the platform x-position and the 16-slot color stack (`pos_x`, `colors`) that the renderer consumes.
- Also spawns and advances one falling layer. Detects catch or miss against the current stack top.
- All state advances on a one-cycle game-step pulse (`tick`). Outputs are registered.

Parameters:
- X_INIT, 260, platform x after reset/restart
- X_MAX, 540, maximum `pos_x` (640 minus WIDTH); minimum is 0
- STEP, 4, platform pixels moved per tick
- WIDTH, 100, layer/platform width in pixels
- LAYER_H, 20, layer height in pixels
- BASE_Y, 400, y of bottom edge of slot 1 (matches renderer)
- FLOOR_Y, 480, y at which an uncaught layer counts as missed
- FALL_STEP, 2, pixels a falling layer drops per tick
- MAX_MISS, 3, misses that end the game

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  game-step strobe, one clk wide
- start  in  1  one-cycle start/restart pulse
- btn_left  in  1  level, move platform left
- btn_right  in  1  level, move platform right
- pos_x  out  10  platform/stack left x
- colors  out  32  slot i = `colors[2i+1:2i]`; 00 empty, 10 red, 01 green, 11 blue
- height  out  5  occupied slots including base (1..16)
- fall_x  out  10  falling layer left x
- fall_y  out  10  falling layer top y
- fall_color  out  2  falling layer color code
- fall_valid  out  1  falling layer present
- misses  out  2  miss count
- game_over  out  1  high in OVER
- won  out  1  high in WIN

Behaviour:
- One clock domain (`clk`). Reset is synchronous and active-high (`rst`), sampled on the `clk` rising edge.
- Reset values:
  - `pos_x` = X_INIT, `colors` = 32'h0000_0001 (slot 0 green base), `height` = 1.
  - `fall_x` = 0, `fall_y` = 0, `fall_color` = 00, `fall_valid` = 0.
  - `misses` = 0, `game_over` = 0, `won` = 0, state = IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. Advances every clk, including in IDLE. Reset reloads the seed.
- States: IDLE, SPAWN, FALL, OVER, WIN.
- IDLE:
  - Outputs are held.
  - `start` → SPAWN.
- SPAWN (one clk, no tick needed):
  - `fall_x` = {1'b0, lfsr[8:0]} clamped to X_MAX; `fall_y` = 0.
  - `fall_color` = lfsr[10:9], with 00 mapped to 01.
  - `fall_valid` = 1, then → FALL.
- Platform motion, applied in FALL on `tick` only:
  - left only: `pos_x` = max(`pos_x` − STEP, 0).
  - right only: `pos_x` = min(`pos_x` + STEP, X_MAX).
  - both or neither: hold.
  - Use 11-bit intermediate arithmetic so there is no wrap.
- FALL, on `tick`, evaluated on the current registered values:
  - land = `fall_y` >= BASE_Y − `height`·LAYER_H (computed in 11 bits).
  - hit = land and `fall_x` + WIDTH > `pos_x` and `fall_x` < `pos_x` + WIDTH.
  - hit:
    - Write `fall_color` into slot `height`, then `height` += 1, `fall_valid` = 0.
    - If new `height` == 16 → WIN; else → SPAWN.
  - else if `fall_y` + FALL_STEP >= FLOOR_Y:
    - Miss: `fall_valid` = 0, `misses` += 1.
    - If new `misses` == MAX_MISS → OVER; else → SPAWN.
  - else: `fall_y` += FALL_STEP.
  - Once land has passed without a hit, the layer keeps falling past the stack and can no longer be caught; hit is evaluated only while `fall_y` < BASE_Y − (`height`−1)·LAYER_H.
- Timing and ordering:
  - All effects appear one clk after the tick edge.
  - Platform motion and catch evaluation on the same tick both use pre-tick `pos_x`.
- OVER / WIN:
  - `game_over`/`won` high; everything else frozen; ticks ignored.
  - `start` → restore all reset values except the LFSR, → SPAWN.
- `start` is ignored in SPAWN and FALL.
- A `tick` arriving in the SPAWN cycle is dropped.
- `rst` mid-game: immediate return to reset values on the next clk edge, regardless of `tick`/`start`.

Optional Feature:
- Macro: STACK_CTRL_SPEEDUP_EN.
- Defined:
  - Effective fall step = FALL_STEP + (`height`−1)>>2, i.e. +1 pixel per 4 caught layers.
  - Floor and land comparisons use this step.
- Undefined: fall step is fixed at FALL_STEP.

Test Plan:
- `rst`, then 10 ticks with no `start` → `pos_x`=260, `colors`=32'h1, `height`=1, state IDLE, no outputs change.
- `start`; hold `btn_right` for 100 ticks → `pos_x` saturates at 540, no wrap. Hold `btn_left` for 200 ticks → `pos_x`=0. Hold both buttons → `pos_x` unchanged.
- Catch: force `fall_x`=`pos_x`=260, `fall_color`=10, `height`=1, keep ticking until `fall_y`>=380 → `colors`[3:2]=10, `height`=2, SPAWN one clk later.
- Edge overlap:
  - `fall_x`=`pos_x`+99 at land → hit.
  - `fall_x`=`pos_x`+100 → no hit; layer falls to 480, `misses`=1, `colors` unchanged.
- Three misses → `game_over`=1, ticks ignored. `start` → `height`=1, `colors`=32'h1, `misses`=0, `pos_x`=260.
- 15 consecutive catches → `height`=16, `won`=1, all 15 slots non-zero. Assert `rst` during FALL at `height`=5 → all reset values next clk.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// -----------------------------------------------------------------------------
// stack_ctrl_if
// Bundles the game-step controls and the game-state outputs of stack_ctrl.
//   master : drives tick/start/buttons, observes the game state (bench/host)
//   slave  : consumes tick/start/buttons, drives the game state (stack_ctrl)
// Signals:
//   tick        game-step strobe, one clk wide
//   start       one-cycle start/restart pulse
//   btn_left    level, move platform left
//   btn_right   level, move platform right
//   pos_x       platform/stack left x
//   colors      16 x 2-bit slot colors, slot i = colors[2i+1:2i]
//   height      occupied slots including base (1..16)
//   fall_x/y    falling layer left x / top y
//   fall_color  falling layer color code
//   fall_valid  falling layer present
//   misses      miss count
//   game_over   high in OVER
//   won         high in WIN
// -----------------------------------------------------------------------------
interface stack_ctrl_if;
  logic        tick;
  logic        start;
  logic        btn_left;
  logic        btn_right;
  logic [9:0]  pos_x;
  logic [31:0] colors;
  logic [4:0]  height;
  logic [9:0]  fall_x;
  logic [9:0]  fall_y;
  logic [1:0]  fall_color;
  logic        fall_valid;
  logic [1:0]  misses;
  logic        game_over;
  logic        won;

  modport master (
    output tick, start, btn_left, btn_right,
    input  pos_x, colors, height, fall_x, fall_y, fall_color, fall_valid,
           misses, game_over, won
  );

  modport slave (
    input  tick, start, btn_left, btn_right,
    output pos_x, colors, height, fall_x, fall_y, fall_color, fall_valid,
           misses, game_over, won
  );
endinterface

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Game-state stage feeding the stack renderer. Owns the platform x-position and
// the 16-slot color stack, spawns one falling layer at a time, moves it down on
// each game tick and decides catch or miss against the current stack top.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  stack_ctrl_if.slave (tick/start/buttons in, game state out)
// All outputs are registered.
// Optional feature macro: STACK_CTRL_SPEEDUP_EN
//   defined   -> fall step grows by one pixel per four caught layers
//   undefined -> fixed fall step of FALL_STEP
// -----------------------------------------------------------------------------
module stack_ctrl #(
  parameter int X_INIT    = 260,
  parameter int X_MAX     = 540,
  parameter int STEP      = 4,
  parameter int WIDTH     = 100,
  parameter int LAYER_H   = 20,
  parameter int BASE_Y    = 400,
  parameter int FLOOR_Y   = 480,
  parameter int FALL_STEP = 2,
  parameter int MAX_MISS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  stack_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SPAWN, FALL, OVER, WIN} state_t;

  // 11-bit views of the geometry so no comparison or sum can wrap
  localparam logic [10:0] X_MAX11     = 11'(X_MAX);
  localparam logic [10:0] STEP11      = 11'(STEP);
  localparam logic [10:0] WIDTH11     = 11'(WIDTH);
  localparam logic [10:0] LAYER_H11   = 11'(LAYER_H);
  localparam logic [10:0] BASE_Y11    = 11'(BASE_Y);
  localparam logic [10:0] FLOOR_Y11   = 11'(FLOOR_Y);
  localparam logic [10:0] FALL_STEP11 = 11'(FALL_STEP);
  localparam logic [9:0]  X_INIT10    = 10'(X_INIT);
  localparam logic [1:0]  MAX_MISS2   = 2'(MAX_MISS);
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  state_t      state_r;
  logic [15:0] lfsr_r;
  logic [9:0]  pos_x_r;
  logic [31:0] colors_r;
  logic [4:0]  height_r;
  logic [9:0]  fall_x_r;
  logic [9:0]  fall_y_r;
  logic [1:0]  fall_color_r;
  logic        fall_valid_r;
  logic [1:0]  misses_r;
  logic        game_over_r;
  logic        won_r;

  logic        lfsr_fb_s;
  logic [10:0] px_s, fx_s, fy_s, step_s, land_y_s, spawn_x_s;
  logic        land_s, catchable_s, overlap_s, hit_s, floor_s;
  logic [9:0]  pos_next_s, fall_y_next_s, spawn_x10_s;
  logic [4:0]  height_inc_s;
  logic [1:0]  misses_inc_s, spawn_color_s;
  logic [31:0] colors_wr_s;

  // Next-state helpers: LFSR feedback, catch/miss tests, platform motion, spawn
  always_comb begin
    lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    px_s      = {1'b0, pos_x_r};
    fx_s      = {1'b0, fall_x_r};
    fy_s      = {1'b0, fall_y_r};
`ifdef STACK_CTRL_SPEEDUP_EN
    step_s    = FALL_STEP11 + 11'((height_r - 5'd1) >> 2);
`else
    step_s    = FALL_STEP11;
`endif
    // Top edge of the current stack; the layer can only be caught in the
    // one-layer band just above it, after that it falls past the stack.
    land_y_s     = BASE_Y11 - (11'(height_r) * LAYER_H11);
    land_s       = (fy_s >= land_y_s);
    catchable_s  = (fy_s < (land_y_s + LAYER_H11));
    overlap_s    = ((fx_s + WIDTH11) > px_s) && (fx_s < (px_s + WIDTH11));
    hit_s        = land_s && catchable_s && overlap_s;
    floor_s      = ((fy_s + step_s) >= FLOOR_Y11);
    fall_y_next_s = 10'(fy_s + step_s);
    height_inc_s = height_r + 5'd1;
    misses_inc_s = misses_r + 2'd1;

    colors_wr_s = colors_r;
    colors_wr_s[{height_r[3:0], 1'b0} +: 2] = fall_color_r;

    spawn_x_s = {2'b00, lfsr_r[8:0]};
    if (spawn_x_s > X_MAX11) begin
      spawn_x10_s = 10'(X_MAX11);
    end else begin
      spawn_x10_s = 10'(spawn_x_s);
    end
    spawn_color_s = (lfsr_r[10:9] == 2'b00) ? 2'b01 : lfsr_r[10:9];

    // Exactly one button moves the platform; both or neither hold it
    if (bus.btn_left && !bus.btn_right) begin
      if (px_s >= STEP11) begin
        pos_next_s = 10'(px_s - STEP11);
      end else begin
        pos_next_s = 10'd0;
      end
    end else if (bus.btn_right && !bus.btn_left) begin
      if ((px_s + STEP11) > X_MAX11) begin
        pos_next_s = 10'(X_MAX11);
      end else begin
        pos_next_s = 10'(px_s + STEP11);
      end
    end else begin
      pos_next_s = pos_x_r;
    end
  end

  // Game FSM with all outputs registered; LFSR free-runs every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      lfsr_r       <= LFSR_SEED;
      pos_x_r      <= X_INIT10;
      colors_r     <= 32'h0000_0001;
      height_r     <= 5'd1;
      fall_x_r     <= 10'd0;
      fall_y_r     <= 10'd0;
      fall_color_r <= 2'b00;
      fall_valid_r <= 1'b0;
      misses_r     <= 2'd0;
      game_over_r  <= 1'b0;
      won_r        <= 1'b0;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r <= SPAWN;
          end
        end
        SPAWN: begin
          // A tick landing in this cycle is intentionally dropped
          fall_x_r     <= spawn_x10_s;
          fall_y_r     <= 10'd0;
          fall_color_r <= spawn_color_s;
          fall_valid_r <= 1'b1;
          state_r      <= FALL;
        end
        FALL: begin
          if (bus.tick) begin
            // Motion and catch test both see the pre-tick platform position
            pos_x_r <= pos_next_s;
            if (hit_s) begin
              colors_r     <= colors_wr_s;
              height_r     <= height_inc_s;
              fall_valid_r <= 1'b0;
              if (height_inc_s == 5'd16) begin
                won_r   <= 1'b1;
                state_r <= WIN;
              end else begin
                state_r <= SPAWN;
              end
            end else if (floor_s) begin
              fall_valid_r <= 1'b0;
              misses_r     <= misses_inc_s;
              if (misses_inc_s == MAX_MISS2) begin
                game_over_r <= 1'b1;
                state_r     <= OVER;
              end else begin
                state_r <= SPAWN;
              end
            end else begin
              fall_y_r <= fall_y_next_s;
            end
          end
        end
        OVER, WIN: begin
          // Restart restores the reset picture but keeps the LFSR running
          if (bus.start) begin
            state_r      <= SPAWN;
            pos_x_r      <= X_INIT10;
            colors_r     <= 32'h0000_0001;
            height_r     <= 5'd1;
            fall_x_r     <= 10'd0;
            fall_y_r     <= 10'd0;
            fall_color_r <= 2'b00;
            fall_valid_r <= 1'b0;
            misses_r     <= 2'd0;
            game_over_r  <= 1'b0;
            won_r        <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.pos_x      = pos_x_r;
  assign bus.colors     = colors_r;
  assign bus.height     = height_r;
  assign bus.fall_x     = fall_x_r;
  assign bus.fall_y     = fall_y_r;
  assign bus.fall_color = fall_color_r;
  assign bus.fall_valid = fall_valid_r;
  assign bus.misses     = misses_r;
  assign bus.game_over  = game_over_r;
  assign bus.won        = won_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
// Randomized self-checking bench for stack_ctrl. A driver issues one set of
// inputs per clock, advances a behavioural game model (stack kept as a queue of
// colors) and pushes the expected post-edge output picture into a queue. A
// separate monitor pops one expected picture after every rising edge and
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_SPAWN = 1;
  localparam int M_FALL  = 2;
  localparam int M_OVER  = 3;
  localparam int M_WIN   = 4;

  typedef struct packed {
    logic [9:0]  pos_x;
    logic [31:0] colors;
    logic [4:0]  height;
    logic [9:0]  fall_x;
    logic [9:0]  fall_y;
    logic [1:0]  fall_color;
    logic        fall_valid;
    logic [1:0]  misses;
    logic        game_over;
    logic        won;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_ctrl_if bus ();

  stack_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  snap_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  // behavioural model state
  int       m_mode;
  int       m_px, m_fx, m_fy, m_fc, m_misses;
  bit       m_valid;
  int       stack_q[$];
  bit [15:0] m_lfsr;

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_clear();
    m_px = 260; m_fx = 0; m_fy = 0; m_fc = 0; m_valid = 1'b0; m_misses = 0;
    stack_q = {};
    stack_q.push_back(1);
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    bit [31:0] c;
    c = 32'h0;
    foreach (stack_q[i]) c[2*i +: 2] = 2'(stack_q[i]);
    s.pos_x      = 10'(m_px);
    s.colors     = c;
    s.height     = 5'(stack_q.size());
    s.fall_x     = 10'(m_fx);
    s.fall_y     = 10'(m_fy);
    s.fall_color = 2'(m_fc);
    s.fall_valid = m_valid;
    s.misses     = 2'(m_misses);
    s.game_over  = (m_mode == M_OVER);
    s.won        = (m_mode == M_WIN);
    return s;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit s, input bit bl, input bit br);
    bit [15:0] cur;
    int h, stp, top;
    bit hit;
    if (r) begin
      model_clear();
      m_mode = M_IDLE;
      m_lfsr = 16'hACE1;
    end else begin
      cur    = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      case (m_mode)
        M_IDLE: if (s) m_mode = M_SPAWN;
        M_SPAWN: begin
          m_fx = int'(cur[8:0]);
          if (m_fx > 540) m_fx = 540;
          m_fy = 0;
          m_fc = int'(cur[10:9]);
          if (m_fc == 0) m_fc = 1;
          m_valid = 1'b1;
          m_mode = M_FALL;
        end
        M_FALL: begin
          if (t) begin
            h   = stack_q.size();
            stp = 2;
`ifdef STACK_CTRL_SPEEDUP_EN
            stp = 2 + (h - 1) / 4;
`endif
            top = 400 - h * 20;
            hit = (m_fy >= top) && (m_fy < top + 20) &&
                  (m_fx + 100 > m_px) && (m_fx < m_px + 100);
            if (bl && !br) m_px = (m_px < 4) ? 0 : m_px - 4;
            else if (br && !bl) m_px = (m_px + 4 > 540) ? 540 : m_px + 4;
            if (hit) begin
              stack_q.push_back(m_fc);
              m_valid = 1'b0;
              m_mode  = (stack_q.size() == 16) ? M_WIN : M_SPAWN;
            end else if (m_fy + stp >= 480) begin
              m_valid  = 1'b0;
              m_misses = m_misses + 1;
              m_mode   = (m_misses == 3) ? M_OVER : M_SPAWN;
            end else begin
              m_fy = m_fy + stp;
            end
          end
        end
        M_OVER, M_WIN: begin
          if (s) begin
            model_clear();
            m_mode = M_SPAWN;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // drive one clock's worth of inputs, predict the outcome, wait for negedge
  task automatic cycle(input bit r, input bit t, input bit s, input bit bl, input bit br);
    rst           = r;
    bus.tick      = t;
    bus.start     = s;
    bus.btn_left  = bl;
    bus.btn_right = br;
    model_step(r, t, s, bl, br);
    exp_q.push_back(model_snap());
    @(negedge clk);
  endtask

  // lim>0: steer into overlap, staying as central as lim allows; lim<0: avoid
  task automatic steer(input int lim, output bit bl, output bit br);
    int tgt;
    bl = 1'b0; br = 1'b0;
    if (m_mode != M_FALL) begin
      bl = 1'($urandom_range(1)); br = 1'($urandom_range(1));
    end else if (lim < 0) begin
      if (m_fx <= 270) br = 1'b1; else bl = 1'b1;
    end else begin
      tgt = 256;
      if (tgt < m_fx - lim) tgt = m_fx - lim;
      if (tgt > m_fx + lim) tgt = m_fx + lim;
      if (tgt < 0) tgt = 0;
      if (tgt > 540) tgt = 540;
      if (m_px + 2 < tgt) br = 1'b1;
      else if (m_px > tgt + 2) bl = 1'b1;
      else if ($urandom_range(7) == 0) begin bl = 1'b1; br = 1'b1; end
    end
  endtask

  task automatic play_cycle(input int lim);
    bit t, s, bl, br;
    t = ($urandom_range(3) != 0);
    s = ((m_mode == M_FALL || m_mode == M_SPAWN) && $urandom_range(31) == 0);
    steer(lim, bl, br);
    cycle(1'b0, t, s, bl, br);
  endtask

  // monitor: one expected picture per rising edge
  initial begin
    snap_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act.pos_x      = bus.pos_x;
        act.colors     = bus.colors;
        act.height     = bus.height;
        act.fall_x     = bus.fall_x;
        act.fall_y     = bus.fall_y;
        act.fall_color = bus.fall_color;
        act.fall_valid = bus.fall_valid;
        act.misses     = bus.misses;
        act.game_over  = bus.game_over;
        act.won        = bus.won;
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL snap t=%0t got pos_x=%0d colors=%h height=%0d fall=(%0d,%0d,c%0d,v%0b) misses=%0d over=%0b won=%0b exp pos_x=%0d colors=%h height=%0d fall=(%0d,%0d,c%0d,v%0b) misses=%0d over=%0b won=%0b",
                   $time, act.pos_x, act.colors, act.height, act.fall_x, act.fall_y,
                   act.fall_color, act.fall_valid, act.misses, act.game_over, act.won,
                   e.pos_x, e.colors, e.height, e.fall_x, e.fall_y,
                   e.fall_color, e.fall_valid, e.misses, e.game_over, e.won);
        end
      end
    end
  end

  // driver: scripted phases with randomized play
  initial begin
    int n;
    // reset, then ticks without start: everything must hold
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));

    // start, saturate right, saturate left, both buttons hold
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)  cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // dodge every layer until the game is over, then ticks must be ignored
    n = 0;
    while (m_mode != M_OVER && n < 4000) begin play_cycle(-1); n++; end
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // catch everything until the stack is full (restart if a game is lost)
    n = 0;
    while (m_mode != M_WIN && n < 20000) begin
      if (m_mode == M_OVER) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else play_cycle(96);
      n++;
    end
    for (int i = 0; i < 20; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // overlap-edge play up to height 5, then reset in the middle of a fall
    n = 0;
    while (!(m_mode == M_FALL && stack_q.size() == 5 && m_fy > 20) && n < 12000) begin
      if (m_mode == M_OVER || m_mode == M_WIN) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else play_cycle(99);
      n++;
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) play_cycle(96);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
